// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//
// Contents:
//   UART_OVERSAMPLE / UART_DATA_BITS : default tick-per-bit and frame width
//   uart_state_e                     : frame-level FSM states (rx and tx)
//   uart_rx_status_t                 : registered per-frame completion flags
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    // PARITY is only reachable when the parity option is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Flags produced together at the end of a frame; errors only
    // carry meaning while done is high.
    typedef struct packed {
        logic done;
        logic frame_err;
        logic parity_err;
    } uart_rx_status_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for an asynchronous level input.
//
// Resets to 1 so an idle-high serial line does not show a spurious
// falling edge when reset releases.
//
// Ports:
//   clk   : sampling clock
//   reset : synchronous, active-high; loads both flops with 1
//   d     : asynchronous input
//   q     : synchronized output (two clk of latency)
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= 2'b11;
        else       ff <= {ff[0], d};
    end

    assign q = ff[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- oversampling UART receiver (start, DATA_BITS LSB-first,
// optional even parity, one stop bit).
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit
// between the data bits and the stop bit. The port list is the same in
// both builds; parity_err stays 0 when the option is off.
//
// Ports:
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   tick       : one-clk strobe at OVERSAMPLE x baud; FSM moves only on it
//   rx         : asynchronous serial line, idle high
//   data       : last received word, held between rx_done pulses
//   rx_done    : one-clk pulse, the clk after the stop-bit sample
//   frame_err  : with rx_done, stop bit sampled low
//   parity_err : with rx_done, even-parity mismatch (parity build only)
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS) + 1;

    // Start bit is checked half a bit in; every later bit one full bit on,
    // so all samples land mid-bit.
    localparam logic [SW-1:0] S_HALF   = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic rx_s;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    uart_state_e          state_q,  state_d;
    logic [SW-1:0]        s_cnt_q,  s_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 armed_q,  armed_d;
    logic [DATA_BITS-1:0] shreg_q,  shreg_d;
    logic [DATA_BITS-1:0] data_q,   data_d;
    uart_rx_status_t      stat_q,   stat_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q,    par_d;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            s_cnt_q   <= '0;
            bit_cnt_q <= '0;
            armed_q   <= 1'b0;
            shreg_q   <= '0;
            data_q    <= '0;
            stat_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s_cnt_q   <= s_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            armed_q   <= armed_d;
            shreg_q   <= shreg_d;
            data_q    <= data_d;
            stat_q    <= stat_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Next-state logic. Status flags default to 0 every clk, which makes
    // rx_done a single-clk pulse and keeps the error flags qualified by it.
    always_comb begin
        state_d   = state_q;
        s_cnt_d   = s_cnt_q;
        bit_cnt_d = bit_cnt_q;
        armed_d   = armed_q;
        shreg_d   = shreg_q;
        data_d    = data_q;
        stat_d    = '0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
`endif

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    // armed requires the line to have been seen high, so a
                    // held-low break after a frame error never restarts.
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        state_d = START;
                        s_cnt_d = '0;
                    end
                end

                START: begin
                    if (s_cnt_q == S_HALF) begin
                        s_cnt_d = '0;
                        if (!rx_s) begin
                            state_d   = DATA;
                            bit_cnt_d = '0;
                        end else begin
                            state_d = IDLE;   // glitch, not a start bit
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end

                DATA: begin
                    if (s_cnt_q == S_LAST) begin
                        // LSB arrives first, so shift right from the top.
                        shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                        s_cnt_d   = '0;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end

                PARITY: begin
`ifdef UART_RX_PARITY_EN
                    if (s_cnt_q == S_LAST) begin
                        par_d   = rx_s;
                        s_cnt_d = '0;
                        state_d = STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
`else
                    state_d = IDLE;
                    s_cnt_d = '0;
`endif
                end

                STOP: begin
                    if (s_cnt_q == S_LAST) begin
                        data_d           = shreg_q;
                        stat_d.done      = 1'b1;
                        stat_d.frame_err = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        stat_d.parity_err = (^shreg_q) ^ par_q;
`endif
                        // A low stop bit may be a break; wait for idle.
                        if (!rx_s) armed_d = 1'b0;
                        s_cnt_d = '0;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + SW'(1);
                    end
                end

                default: begin
                    state_d = IDLE;
                    s_cnt_d = '0;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign rx_done    = stat_q.done;
    assign frame_err  = stat_q.frame_err;
    assign parity_err = stat_q.parity_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed plus randomized frames for uart_rx, checked
// against a frame-level reference model.
module tb_uart_rx;

    localparam int OS   = 16;
    localparam int DB   = 8;
    localparam int TDIV = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          rx;
    logic [DB-1:0] data;
    logic          rx_done;
    logic          frame_err;
    logic          parity_err;

    int vectors     = 0;
    int miscompares = 0;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .rx         (rx),
        .data       (data),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Tick strobe: one clk in TDIV.
    int tcnt = 0;
    always @(posedge clk) tcnt <= (tcnt == TDIV - 1) ? 0 : tcnt + 1;
    assign tick = (tcnt == TDIV - 1);

    event tick_ev;
    always @(posedge clk) if (tick) -> tick_ev;

    // Monitor: capture each completed frame and watch pulse protocol.
    typedef struct packed {
        logic [DB-1:0] d;
        logic          fe;
        logic          pe;
    } evt_t;

    evt_t          q[$];
    int            proto_bad = 0;
    logic          done_d    = 1'b0;
    logic [DB-1:0] last_data = '0;

    always @(negedge clk) begin
        if (rx_done) begin
            q.push_back(evt_t'({data, frame_err, parity_err}));
            last_data <= data;
        end
        if (rx_done && done_d) proto_bad <= proto_bad + 1;
        if (!rx_done && (frame_err || parity_err)) proto_bad <= proto_bad + 1;
        if (reset) last_data <= '0;
        else if (!rx_done && data !== last_data) proto_bad <= proto_bad + 1;
        done_d <= rx_done;
    end

    // Reference model: what a frame of the given line bits should report.
    function automatic evt_t model(logic [DB-1:0] b, logic stop, logic pbit);
        evt_t e;
        e.d  = b;
        e.fe = ~stop;
`ifdef UART_RX_PARITY_EN
        e.pe = (^b) ^ pbit;
`else
        e.pe = 1'b0;
`endif
        return e;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(int n);
        if (n > 0) begin
            repeat (n) @(tick_ev);
            #1;
        end
    endtask

    task automatic idle(int n);
        rx = 1'b1;
        wait_ticks(n);
    endtask

    // Drives one frame; leaves rx at the stop-bit level.
    task automatic send_frame(logic [DB-1:0] b, logic stop, logic pbit);
        logic [DB+2:0] bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) bits.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
        bits.push_back(pbit);
`endif
        bits.push_back(stop);
        foreach (bits[i]) begin
            rx = bits[i][0];
            wait_ticks(OS);
        end
    endtask

    task automatic expect_frame(string tag, logic [DB-1:0] b, logic stop, logic pbit);
        evt_t e, x;
        x = model(b, stop, pbit);
        chk({tag, ".count"}, q.size(), 1);
        e = (q.size() > 0) ? q.pop_front() : evt_t'('x);
        chk({tag, ".data"},       e.d,  x.d);
        chk({tag, ".frame_err"},  e.fe, x.fe);
        chk({tag, ".parity_err"}, e.pe, x.pe);
    endtask

    initial begin
        evt_t e;
        logic [DB-1:0] b;
        logic stop, pbit;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.data",       data,       0);
        chk("reset.rx_done",    rx_done,    0);
        chk("reset.frame_err",  frame_err,  0);
        chk("reset.parity_err", parity_err, 0);
        reset = 1'b0;
        idle(4);

        // Clean frame
        send_frame(8'hA5, 1'b1, ^8'hA5);
        idle(2);
        expect_frame("a5", 8'hA5, 1'b1, ^8'hA5);

        // Short low glitch is not a start bit
        rx = 1'b0;
        wait_ticks(4);
        idle(2 * OS);
        chk("glitch.count", q.size(), 0);
        chk("glitch.data",  data, 8'hA5);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        idle(2);
        expect_frame("after_glitch", 8'h5A, 1'b1, ^8'h5A);

        // Frame error, then a held-low break
        send_frame(8'h3C, 1'b0, ^8'h3C);
        wait_ticks(40);
        expect_frame("ferr", 8'h3C, 1'b0, ^8'h3C);
        idle(2);
        chk("break.count", q.size(), 0);
        send_frame(8'h96, 1'b1, ^8'h96);
        idle(2);
        expect_frame("after_break", 8'h96, 1'b1, ^8'h96);

        // Back-to-back, no idle gap
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        idle(2);
        chk("b2b.count", q.size(), 2);
        e = (q.size() > 0) ? q.pop_front() : evt_t'('x);
        chk("b2b.first", e, model(8'h00, 1'b1, 1'b0));
        e = (q.size() > 0) ? q.pop_front() : evt_t'('x);
        chk("b2b.second", e, model(8'hFF, 1'b1, 1'b0));

        // Reset in the middle of bit 4 of 0x55
        b  = 8'h55;
        rx = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_ticks(OS);
        end
        rx = b[4];
        wait_ticks(OS / 2);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2 * OS);
        chk("midreset.count", q.size(), 0);
        chk("midreset.data",  data, 0);
        send_frame(8'h81, 1'b1, ^8'h81);
        idle(2);
        expect_frame("after_reset", 8'h81, 1'b1, ^8'h81);

        // Parity cases (parity_err stays 0 in the non-parity build)
        send_frame(8'h07, 1'b1, 1'b0);
        idle(2);
        expect_frame("par0", 8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(2);
        expect_frame("par1", 8'h07, 1'b1, 1'b1);

        // Random frames with random gaps; a bad stop gets a real idle after it
        for (int n = 0; n < 25; n++) begin
            b    = DB'($urandom);
            stop = ($urandom_range(0, 5) != 0);
            pbit = 1'($urandom);
            send_frame(b, stop, pbit);
            expect_frame("rand", b, stop, pbit);
            idle(stop ? $urandom_range(0, 3) : $urandom_range(2, 4));
        end

        idle(2 * OS);
        chk("end.queue_empty", q.size(), 0);
        chk("end.protocol",    proto_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
